// File: rtl/noc_credit_link_buffer.sv
// -----------------------------------------------------------------------------
// noc_credit_link_buffer
//
// Credit-based repeater between a router output port and the next router's
// input port. Toward the upstream router it behaves as a receiving endpoint:
// it buffers flits and returns one credit per flit drained. Toward the
// downstream router it behaves as a sender: it holds that router's credits and
// forwards a flit only while a credit is held. This lets a long link be
// retimed and buffered without changing either router's credit accounting.
//
// Ports
//   clk_noc       in   NoC clock (single domain)
//   rst_noc_sync  in   synchronous active-high reset
//   data_in       in   flit payload from upstream
//   dest_in       in   flit destination
//   is_tail_in    in   last flit of packet (carried, not interpreted)
//   send_in       in   flit valid (upstream spent a credit)
//   credit_out    out  one-cycle pulse: one local FIFO slot freed
//   data_out      out  registered flit payload to downstream
//   dest_out      out  registered destination
//   is_tail_out   out  registered tail marker
//   send_out      out  registered flit valid to downstream
//   credit_in     in   one-cycle pulse: downstream freed one slot
//   fifo_count    out  local FIFO occupancy
//   credit_count  out  downstream credits currently held
//   overflow_err  out  sticky: send_in arrived while FIFO full
//   credit_err    out  sticky: credit_in arrived with all credits held
// -----------------------------------------------------------------------------
module noc_credit_link_buffer #(
  parameter int FLIT_WIDTH         = 32,
  parameter int DEST_WIDTH         = 6,
  parameter int BUFFER_DEPTH       = 4,
  parameter int DOWNSTREAM_CREDITS = 4,
  parameter int CNT_WIDTH          = $clog2((BUFFER_DEPTH > DOWNSTREAM_CREDITS) ?
                                            BUFFER_DEPTH : DOWNSTREAM_CREDITS) + 1
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc_sync,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic [CNT_WIDTH-1:0]  credit_count,
  output logic                  overflow_err,
  output logic                  credit_err
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(BUFFER_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CRED_C  = CNT_WIDTH'(DOWNSTREAM_CREDITS);
  localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  tail;
  } flit_t;

  flit_t                mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] fifo_count_q, fifo_count_d;
  logic [CNT_WIDTH-1:0] credit_count_q, credit_count_d;
  flit_t                out_q, out_d;
  logic                 send_out_q, send_out_d;
  logic                 credit_out_q, credit_out_d;
  logic                 overflow_q, overflow_d;
  logic                 credit_err_q, credit_err_d;
  logic                 push, pop;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    // Fullness uses the registered count: a slot freed by a pop at this edge
    // is not reusable until the next cycle, so a full FIFO still drops.
    push = send_in && (fifo_count_q != DEPTH_C);
    pop  = (fifo_count_q != '0) && (credit_count_q != '0);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    fifo_count_d = fifo_count_q;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + ONE_C;
      2'b01:   fifo_count_d = fifo_count_q - ONE_C;
      default: fifo_count_d = fifo_count_q;
    endcase

    // A returned credit while all credits are held is a protocol error; the
    // count saturates rather than wrapping.
    credit_count_d = credit_count_q;
    if (pop && !credit_in) begin
      credit_count_d = credit_count_q - ONE_C;
    end else if (credit_in && !pop && (credit_count_q != CRED_C)) begin
      credit_count_d = credit_count_q + ONE_C;
    end

    overflow_d   = overflow_q   | (send_in && !push);
    credit_err_d = credit_err_q | (credit_in && (credit_count_q == CRED_C));

    // Output flit holds its last value when idle; only send_out qualifies it.
    out_d        = pop ? mem_q[rd_ptr_q] : out_q;
    send_out_d   = pop;
    credit_out_d = pop;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_count_q   <= '0;
      credit_count_q <= CRED_C;
      out_q          <= '0;
      send_out_q     <= 1'b0;
      credit_out_q   <= 1'b0;
      overflow_q     <= 1'b0;
      credit_err_q   <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_count_q   <= fifo_count_d;
      credit_count_q <= credit_count_d;
      out_q          <= out_d;
      send_out_q     <= send_out_d;
      credit_out_q   <= credit_out_d;
      overflow_q     <= overflow_d;
      credit_err_q   <= credit_err_d;
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by fifo_count, so stale
  // entries are never read and the array can map onto plain RAM/flops.
  always_ff @(posedge clk_noc) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{data: data_in, dest: dest_in, tail: is_tail_in};
    end
  end

  assign data_out     = out_q.data;
  assign dest_out     = out_q.dest;
  assign is_tail_out  = out_q.tail;
  assign send_out     = send_out_q;
  assign credit_out   = credit_out_q;
  assign fifo_count   = fifo_count_q;
  assign credit_count = credit_count_q;
  assign overflow_err = overflow_q;
  assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_noc_credit_link_buffer.sv
// -----------------------------------------------------------------------------
// tb_noc_credit_link_buffer
//
// Directed bench for noc_credit_link_buffer with default parameters
// (BUFFER_DEPTH = DOWNSTREAM_CREDITS = 4). Inputs change 1 ns after a rising
// edge; registered outputs are read in the same window, so a value read
// "in cycle c" is the state left by the edge that opened cycle c.
// -----------------------------------------------------------------------------
module tb_noc_credit_link_buffer;

  localparam int FW = 32;
  localparam int DW = 6;
  localparam int CW = 3;

  logic          clk_noc = 1'b0;
  logic          rst_noc_sync;
  logic [FW-1:0] data_in;
  logic [DW-1:0] dest_in;
  logic          is_tail_in;
  logic          send_in;
  logic          credit_out;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] credit_count;
  logic          overflow_err;
  logic          credit_err;

  int checks = 0;
  int errors = 0;

  always #5 clk_noc = ~clk_noc;

  noc_credit_link_buffer dut (
    .clk_noc      (clk_noc),
    .rst_noc_sync (rst_noc_sync),
    .data_in      (data_in),
    .dest_in      (dest_in),
    .is_tail_in   (is_tail_in),
    .send_in      (send_in),
    .credit_out   (credit_out),
    .data_out     (data_out),
    .dest_out     (dest_out),
    .is_tail_out  (is_tail_out),
    .send_out     (send_out),
    .credit_in    (credit_in),
    .fifo_count   (fifo_count),
    .credit_count (credit_count),
    .overflow_err (overflow_err),
    .credit_err   (credit_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_noc);
    #1;
  endtask

  int          n_send, n_cred, n_got;
  logic [31:0] got_q [8];
  logic [31:0] exp_q [4];

  initial begin
    rst_noc_sync = 1'b1;
    data_in      = '0;
    dest_in      = '0;
    is_tail_in   = 1'b0;
    send_in      = 1'b0;
    credit_in    = 1'b0;
    step();
    step();
    rst_noc_sync = 1'b0;

    // ---- reset state ----
    check("rst_fifo_count", fifo_count, 0);
    check("rst_credit_count", credit_count, 4);
    check("rst_send_out", send_out, 0);
    check("rst_credit_out", credit_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_dest_out", dest_out, 0);
    check("rst_tail_out", is_tail_out, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_credit_err", credit_err, 0);

    // ---- single flit, t+2 latency ----
    data_in = 32'hDEAD_BEEF; dest_in = 6'h05; is_tail_in = 1'b1; send_in = 1'b1;
    step();                                      // cycle t+1
    send_in = 1'b0; data_in = '0; dest_in = '0; is_tail_in = 1'b0;
    check("one_t1_send", send_out, 0);
    check("one_t1_fifo", fifo_count, 1);
    step();                                      // cycle t+2
    check("one_t2_send", send_out, 1);
    check("one_t2_credit_out", credit_out, 1);
    check("one_t2_data", data_out, 64'hDEAD_BEEF);
    check("one_t2_dest", dest_out, 5);
    check("one_t2_tail", is_tail_out, 1);
    check("one_t2_credits", credit_count, 3);
    check("one_t2_fifo", fifo_count, 0);
    step();
    check("one_t3_send", send_out, 0);
    check("one_t3_credit_out", credit_out, 0);
    check("one_t3_data_hold", data_out, 64'hDEAD_BEEF);
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    check("one_credit_back", credit_count, 4);

    // ---- 8-flit burst, credit returned every cycle from first send_out ----
    for (int c = 0; c <= 10; c++) begin
      send_in    = (c < 8);
      data_in    = 32'hA000_0000 + 32'(c);
      dest_in    = DW'(c);
      is_tail_in = (c == 7);
      credit_in  = (c >= 2 && c < 10);
      check($sformatf("burst_send_%0d", c), send_out, (c >= 2 && c < 10));
      check($sformatf("burst_cout_%0d", c), credit_out, (c >= 2 && c < 10));
      check($sformatf("burst_credits_%0d", c), credit_count, (c >= 2 && c < 10) ? 3 : 4);
      if (c >= 2 && c < 10) begin
        check($sformatf("burst_data_%0d", c), data_out, 64'hA000_0000 + 64'(c - 2));
        check($sformatf("burst_dest_%0d", c), dest_out, 64'(c - 2));
        check($sformatf("burst_tail_%0d", c), is_tail_out, (c == 9));
      end
      step();
    end
    send_in = 1'b0; credit_in = 1'b0; is_tail_in = 1'b0;
    check("burst_fifo_end", fifo_count, 0);
    check("burst_overflow", overflow_err, 0);
    check("burst_credit_err", credit_err, 0);

    // ---- 6 flits, no credits returned ----
    n_send = 0;
    n_cred = 0;
    for (int c = 0; c < 10; c++) begin
      send_in = (c < 6);
      data_in = 32'h0000_00B0 + 32'(c);
      dest_in = 6'h11;
      if (send_out) begin
        check($sformatf("nocred_data_%0d", n_send), data_out, 64'hB0 + 64'(n_send));
        n_send++;
      end
      if (credit_out) n_cred++;
      step();
    end
    send_in = 1'b0;
    check("nocred_send_pulses", n_send, 4);
    check("nocred_credit_pulses", n_cred, 4);
    check("nocred_fifo", fifo_count, 2);
    check("nocred_credits", credit_count, 0);
    check("nocred_overflow", overflow_err, 0);
    credit_in = 1'b1;
    step();                                      // cycle k+1
    credit_in = 1'b0;
    check("fifth_k1_send", send_out, 0);
    check("fifth_k1_credits", credit_count, 1);
    step();                                      // cycle k+2
    check("fifth_k2_send", send_out, 1);
    check("fifth_k2_data", data_out, 64'hB4);
    check("fifth_k2_credits", credit_count, 0);
    check("fifth_k2_fifo", fifo_count, 1);

    // ---- fill to 4 with no credits, then overflow ----
    for (int i = 0; i < 3; i++) begin
      send_in = 1'b1;
      data_in = 32'h0000_00C0 + 32'(i);
      step();
    end
    send_in = 1'b0;
    check("full_fifo", fifo_count, 4);
    check("full_no_overflow_yet", overflow_err, 0);
    send_in = 1'b1;
    data_in = 32'hBAD0_BAD0;
    step();
    send_in = 1'b0;
    check("ovf_flag", overflow_err, 1);
    check("ovf_fifo_stays", fifo_count, 4);
    // Drain: dropped flit must not appear; order preserved.
    exp_q = '{32'h0000_00B5, 32'h0000_00C0, 32'h0000_00C1, 32'h0000_00C2};
    n_got = 0;
    for (int c = 0; c < 8; c++) begin
      credit_in = (c < 4);
      if (send_out && n_got < 8) begin
        got_q[n_got] = data_out;
        n_got++;
      end
      step();
    end
    credit_in = 1'b0;
    check("drain_count", n_got, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_data_%0d", i), got_q[i], exp_q[i]);
    end
    check("drain_fifo", fifo_count, 0);
    check("drain_credits", credit_count, 0);
    check("ovf_sticky", overflow_err, 1);

    // ---- reset mid-packet with 3 flits held ----
    for (int i = 0; i < 3; i++) begin
      send_in = 1'b1;
      data_in = 32'h0000_00D0 + 32'(i);
      step();
    end
    send_in = 1'b0;
    check("mid_fifo3", fifo_count, 3);
    rst_noc_sync = 1'b1;
    step();
    rst_noc_sync = 1'b0;
    check("mid_rst_fifo", fifo_count, 0);
    check("mid_rst_credits", credit_count, 4);
    check("mid_rst_send", send_out, 0);
    check("mid_rst_cout", credit_out, 0);
    check("mid_rst_overflow", overflow_err, 0);
    check("mid_rst_credit_err", credit_err, 0);
    data_in = 32'h1234_5678; dest_in = 6'h2A; is_tail_in = 1'b0; send_in = 1'b1;
    step();
    send_in = 1'b0;
    check("post_rst_t1_send", send_out, 0);
    step();
    check("post_rst_t2_send", send_out, 1);
    check("post_rst_t2_data", data_out, 64'h1234_5678);
    check("post_rst_t2_dest", dest_out, 64'h2A);
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    check("post_rst_credits", credit_count, 4);
    check("post_rst_credit_err", credit_err, 0);

    // ---- credit_in at full credit ----
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    check("cerr_credits_sat", credit_count, 4);
    check("cerr_flag", credit_err, 1);
    step();
    step();
    check("cerr_sticky", credit_err, 1);
    check("cerr_credits_hold", credit_count, 4);
    rst_noc_sync = 1'b1;
    step();
    rst_noc_sync = 1'b0;
    check("cerr_cleared", credit_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
